// File: rtl/hsi_tx_sched.sv
// Transmit scheduler for the HSI master link: arbitrates BTC, CCW, SR and TM
// frames onto one transmitter, with bounded repeats, timeouts and an idle gap.
module hsi_tx_sched #(
    parameter int BTC_PERIOD = 48000,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btc_en,
    input  logic       ccw_rdy,
    input  logic       sr_rdy,
    input  logic       tm_rdy,
    output logic       ccw_ack,
    output logic       sr_ack,
    output logic       tm_ack,
    output logic       tx_fail,
    output logic [1:0] tx_sel,
    output logic       tx_start,
    output logic       tx_repeat,
    input  logic       tx_done,
    input  logic       tx_repeat_req,
    output logic       busy,
    output logic [1:0] retry_cnt,
    output logic       btc_missed,
    output logic [1:0] dbg_state
);

    // Handshake: a source holds *_rdy high until its one-cycle *_ack; rdy is
    // only looked at in IDLE, so dropping it after the grant has no effect.

    localparam int BTC_W = $clog2(BTC_PERIOD + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [BTC_W-1:0] BTC_LAST = BTC_W'(BTC_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       retry_q, retry_d;
    logic             redo_q, redo_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BTC_W-1:0] btc_cnt_q, btc_cnt_d;
    logic             btc_pend_q, btc_pend_d;
    logic             missed_q, missed_d;
    logic             ccw_ack_q, ccw_ack_d;
    logic             sr_ack_q, sr_ack_d;
    logic             tm_ack_q, tm_ack_d;
    logic             fail_q, fail_d;

    logic       any_req;
    logic [1:0] win;
    logic       finish;
    logic       btc_clr;
    logic       btc_wrap;

    // Fixed priority: BTC > CCW > SR > TM.
    always_comb begin
        any_req = btc_pend_q | ccw_rdy | sr_rdy | tm_rdy;
        win     = 2'd3;
        if (btc_pend_q)   win = 2'd0;
        else if (ccw_rdy) win = 2'd1;
        else if (sr_rdy)  win = 2'd2;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        retry_d   = retry_q;
        redo_d    = redo_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ccw_ack_d = 1'b0;
        sr_ack_d  = 1'b0;
        tm_ack_d  = 1'b0;
        fail_d    = 1'b0;
        finish    = 1'b0;
        btc_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && any_req) begin
                    sel_d   = win;
                    retry_d = 2'd0;
                    redo_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (tx_done) begin
                    finish    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tx_repeat_req || (to_cnt_q == TO_LAST)) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 2'd1;
                        redo_d  = 1'b1;
                    end else begin
                        finish = 1'b1;
                        fail_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // A pending redo restarts the same frame without arbitration.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = redo_q ? START : IDLE;
                    redo_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            case (sel_q)
                2'd0:    btc_clr   = 1'b1;
                2'd1:    ccw_ack_d = 1'b1;
                2'd2:    sr_ack_d  = 1'b1;
                default: tm_ack_d  = 1'b1;
            endcase
        end
    end

    // A new slot wins over a same-cycle completion so the fresh BTC is not lost.
    always_comb begin
        btc_wrap  = btc_en && (btc_cnt_q == BTC_LAST);
        btc_cnt_d = btc_cnt_q + BTC_W'(1);
        if (!btc_en || btc_wrap) btc_cnt_d = '0;
        btc_pend_d = btc_pend_q;
        if (btc_clr)  btc_pend_d = 1'b0;
        if (btc_wrap) btc_pend_d = 1'b1;
        if (!btc_en)  btc_pend_d = 1'b0;
        missed_d = btc_wrap && btc_pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            retry_q    <= 2'd0;
            redo_q     <= 1'b0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            btc_cnt_q  <= '0;
            btc_pend_q <= 1'b0;
            missed_q   <= 1'b0;
            ccw_ack_q  <= 1'b0;
            sr_ack_q   <= 1'b0;
            tm_ack_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            retry_q    <= retry_d;
            redo_q     <= redo_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            btc_cnt_q  <= btc_cnt_d;
            btc_pend_q <= btc_pend_d;
            missed_q   <= missed_d;
            ccw_ack_q  <= ccw_ack_d;
            sr_ack_q   <= sr_ack_d;
            tm_ack_q   <= tm_ack_d;
            fail_q     <= fail_d;
        end
    end

    assign tx_start   = (state_q == START);
    assign tx_repeat  = (state_q == START) && (retry_q != 2'd0);
    assign busy       = (state_q != IDLE);
    assign tx_sel     = sel_q;
    assign retry_cnt  = retry_q;
    assign ccw_ack    = ccw_ack_q;
    assign sr_ack     = sr_ack_q;
    assign tm_ack     = tm_ack_q;
    assign tx_fail    = fail_q;
    assign btc_missed = missed_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hsi_tx_sched.sv
// Directed bench for hsi_tx_sched: arbitration, gap timing, repeats, drops,
// BTC slots with timeouts, and asynchronous reset mid-frame.
module tb_hsi_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, btc_en, ccw_rdy, sr_rdy, tm_rdy;
    logic       ccw_ack, sr_ack, tm_ack, tx_fail;
    logic [1:0] tx_sel;
    logic       tx_start, tx_repeat;
    logic       tx_done, tx_repeat_req;
    logic       busy;
    logic [1:0] retry_cnt;
    logic       btc_missed;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    hsi_tx_sched #(
        .BTC_PERIOD(100),
        .MAX_RETRY (3),
        .GAP_CYCLES(16),
        .TIMEOUT   (4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .btc_en       (btc_en),
        .ccw_rdy      (ccw_rdy),
        .sr_rdy       (sr_rdy),
        .tm_rdy       (tm_rdy),
        .ccw_ack      (ccw_ack),
        .sr_ack       (sr_ack),
        .tm_ack       (tm_ack),
        .tx_fail      (tx_fail),
        .tx_sel       (tx_sel),
        .tx_start     (tx_start),
        .tx_repeat    (tx_repeat),
        .tx_done      (tx_done),
        .tx_repeat_req(tx_repeat_req),
        .busy         (busy),
        .retry_cnt    (retry_cnt),
        .btc_missed   (btc_missed),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    // Checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, input int max_cyc, output int n);
        n = 0;
        while (!tx_start && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, " start"}, tx_start, 1);
    endtask

    task automatic pulse_done(input string tag, input logic [1:0] sel);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, " ccw_ack"}, ccw_ack, sel == 2'd1);
        check({tag, " sr_ack"},  sr_ack,  sel == 2'd2);
        check({tag, " tm_ack"},  tm_ack,  sel == 2'd3);
        check({tag, " tx_fail"}, tx_fail, 0);
    endtask

    task automatic pulse_req();
        tx_repeat_req = 1'b1;
        tick();
        tx_repeat_req = 1'b0;
    endtask

    task automatic no_start(input string tag, input int ncyc);
        int cnt = 0;
        repeat (ncyc) begin
            tick();
            if (tx_start) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    task automatic tm_case(input string tag, input int nreq);
        int n;
        tm_rdy = 1'b1;
        wait_start(tag, 40, n);
        for (int i = 0; i < 4; i++) begin
            check({tag, " sel"}, tx_sel, 3);
            check({tag, " repeat"}, tx_repeat, i != 0);
            check({tag, " retry"}, retry_cnt, i);
            repeat (2) tick();
            if (i < nreq) begin
                pulse_req();
                if (i < 3) begin
                    check({tag, " early ack"}, tm_ack, 0);
                    check({tag, " retry inc"}, retry_cnt, i + 1);
                    wait_start(tag, 40, n);
                    check({tag, " redo gap"}, n, 16);
                end else begin
                    check({tag, " drop ack"}, tm_ack, 1);
                    check({tag, " drop fail"}, tx_fail, 1);
                    break;
                end
            end else begin
                pulse_done(tag, 2'd3);
                break;
            end
        end
        tm_rdy = 1'b0;
        no_start({tag, " no extra start"}, 40);
        check({tag, " idle"}, busy, 0);
    endtask

    // Main sequence
    initial begin
        int n;
        int starts;
        int misses;
        int other_acks;
        int cyc;
        logic [1:0] exp_sel;

        rst = 1'b1;
        en = 1'b0; btc_en = 1'b0;
        ccw_rdy = 1'b0; sr_rdy = 1'b0; tm_rdy = 1'b0;
        tx_done = 1'b0; tx_repeat_req = 1'b0;
        repeat (3) tick();
        check("rst busy", busy, 0);
        check("rst sel", tx_sel, 0);
        check("rst retry", retry_cnt, 0);
        check("rst start", tx_start, 0);
        check("rst acks", {ccw_ack, sr_ack, tm_ack, tx_fail, btc_missed}, 0);
        check("rst state", dbg_state, 0);

        // Single SR frame, then gap to the next SR start
        rst = 1'b0; en = 1'b1; sr_rdy = 1'b1;
        wait_start("sr1", 10, n);
        check("sr1 latency", n, 1);
        check("sr1 sel", tx_sel, 2);
        check("sr1 repeat", tx_repeat, 0);
        repeat (9) tick();
        pulse_done("sr1", 2'd2);
        wait_start("sr2", 40, n);
        check("sr2 spacing", n, 17);
        sr_rdy = 1'b0;
        repeat (3) tick();
        pulse_done("sr2", 2'd2);
        no_start("sr2 quiet", 30);

        // Simultaneous requests granted by priority
        ccw_rdy = 1'b1; sr_rdy = 1'b1; tm_rdy = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        while (exp_q.size() > 0) begin
            exp_sel = exp_q.pop_front();
            wait_start("prio", 40, n);
            check("prio sel", tx_sel, exp_sel);
            repeat (3) tick();
            pulse_done("prio", exp_sel);
            if (exp_sel == 2'd1) ccw_rdy = 1'b0;
            if (exp_sel == 2'd2) sr_rdy = 1'b0;
            if (exp_sel == 2'd3) tm_rdy = 1'b0;
        end
        no_start("prio quiet", 30);

        // Repeats: three recovered, then four exhausting the budget
        tm_case("tm3", 3);
        tm_case("tm4", 4);

        // en=0 blocks new starts
        en = 1'b0; ccw_rdy = 1'b1;
        no_start("en0 block", 20);
        check("en0 busy", busy, 0);
        en = 1'b1;
        wait_start("en1", 10, n);
        check("en1 latency", n, 1);
        check("en1 sel", tx_sel, 1);
        ccw_rdy = 1'b0;
        repeat (2) tick();
        pulse_done("en1", 2'd1);
        no_start("en1 quiet", 30);

        // BTC slot, left unanswered so it times out four times
        btc_en = 1'b1;
        wait_start("btc", 200, n);
        check("btc first slot", n, 101);
        check("btc sel", tx_sel, 0);
        check("btc repeat", tx_repeat, 0);
        starts = 0; misses = 0; other_acks = 0; cyc = 0;
        while (busy && cyc < 20000) begin
            tick();
            cyc++;
            if (tx_start) starts++;
            if (btc_missed) misses++;
            if (ccw_ack || sr_ack || tm_ack) other_acks++;
        end
        check("btc drop idle", busy, 0);
        check("btc restarts", starts, 3);
        check("btc missed", misses, 164);
        check("btc no acks", other_acks, 0);
        check("btc retry", retry_cnt, 3);
        wait_start("btc next", 200, n);
        check("btc next slot", n, 48);
        check("btc next sel", tx_sel, 0);
        check("btc next retry", retry_cnt, 0);
        repeat (2) tick();
        pulse_done("btc next", 2'd0);
        btc_en = 1'b0;
        no_start("btc off", 40);

        // Asynchronous reset during WAIT of an SR frame
        sr_rdy = 1'b1;
        wait_start("rstw", 10, n);
        repeat (3) tick();
        check("rstw in wait", dbg_state, 2);
        rst = 1'b1;
        #1;
        check("rstw busy", busy, 0);
        check("rstw sel", tx_sel, 0);
        check("rstw retry", retry_cnt, 0);
        check("rstw pulses", {tx_start, ccw_ack, sr_ack, tm_ack, tx_fail}, 0);
        misses = 0;
        repeat (3) begin
            tick();
            if (sr_ack) misses++;
        end
        check("rstw no ack", misses, 0);
        rst = 1'b0;
        wait_start("rstw new", 10, n);
        check("rstw new latency", n, 1);
        check("rstw new sel", tx_sel, 2);
        sr_rdy = 1'b0;
        repeat (2) tick();
        pulse_done("rstw new", 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
